// File: rtl/sd_pkg.sv
// sd_pkg: shared constants, frame field positions and FSM state type for the SD host controller.
package sd_pkg;
    localparam int         FRAME_LEN = 48;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    // Frame bit positions, bit 47 is transmitted first.
    localparam int START_POS = 47;
    localparam int TXB_POS   = 46;
    localparam int IDX_MSB   = 45;
    localparam int IDX_LSB   = 40;
    localparam int ARG_MSB   = 39;
    localparam int ARG_LSB   = 8;
    localparam int CRC_MSB   = 7;
    localparam int CRC_LSB   = 1;
    localparam int END_POS   = 0;
    // Bit-counter landmarks: last CRC-covered bit, last CRC bit, end bit.
    localparam logic [5:0] HDR_LAST = 6'd39;
    localparam logic [5:0] CRC_LAST = 6'd46;
    localparam logic [5:0] END_CNT  = 6'd47;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RESP,
        ST_DONE
    } cmd_state_e;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1, init 0), one input bit per enabled cycle.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = clear ? 7'h00 : en ? ({crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00)) : crc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) crc_q <= 7'h00;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: builds the 48-bit SD command frame with serial CRC7, shifts it out MSB-first
// on CMD, then optionally enables the response receiver until it finishes or times out.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    input  logic        expect_resp,
    input  logic        resp_done,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        resp_en,
    output logic        busy,
    output logic        done,
    output logic        timeout
);
    localparam int TW = $clog2(RESP_TIMEOUT) + 1;

    cmd_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [39:0] hdr_q, hdr_d;
    logic        er_q, er_d, to_flag_q, to_flag_d;
    logic        out_q, out_d, oe_q, oe_d, resp_en_q, resp_en_d;
    logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic [6:0]  crc;
    logic        crc_clear, crc_en, tx_bit;
    logic [5:0]  hdr_idx;
    logic [2:0]  crc_idx;

    sd_crc7 u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (crc_clear),
        .en    (crc_en),
        .din   (tx_bit),
        .crc   (crc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        hdr_d     = hdr_q;
        er_d      = er_q;
        to_flag_d = to_flag_q;
        hdr_idx   = HDR_LAST - cnt_q;
        crc_idx   = 3'(CRC_LAST - cnt_q);
        // Header bits feed the CRC; the CRC register is then read out in place, MSB first.
        tx_bit    = (cnt_q <= HDR_LAST) ? hdr_q[hdr_idx] : (cnt_q <= CRC_LAST) ? crc[crc_idx] : 1'b1;
        crc_clear = 1'b0;
        crc_en    = (state_q == ST_SEND) && (cnt_q <= HDR_LAST);
        out_d     = 1'b1;
        oe_d      = 1'b0;
        resp_en_d = 1'b0;
        busy_d    = state_q != ST_IDLE;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                hdr_d     = {2'b01, cmd_index, argument};
                er_d      = expect_resp;
                cnt_d     = 6'd0;
                tmo_d     = '0;
                to_flag_d = 1'b0;
                crc_clear = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                out_d = tx_bit;
                oe_d  = 1'b1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == END_CNT) begin
                    tmo_d   = '0;
                    state_d = er_q ? ST_WAIT_RESP : ST_DONE;
                end
            end
            ST_WAIT_RESP: begin
                resp_en_d = 1'b1;
                tmo_d     = tmo_q + 1'b1;
                // A response arriving on the terminal cycle still counts as in time.
                if (resp_done) begin
                    to_flag_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (tmo_q == TW'(RESP_TIMEOUT - 1)) begin
                    to_flag_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                timeout_d = to_flag_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            tmo_q     <= '0;
            hdr_q     <= 40'd0;
            er_q      <= 1'b0;
            to_flag_q <= 1'b0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            resp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            hdr_q     <= hdr_d;
            er_q      <= er_d;
            to_flag_q <= to_flag_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            resp_en_q <= resp_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign sd_cmd_out = out_q;
    assign sd_cmd_oe  = oe_q;
    assign resp_en    = resp_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Command-line transmitter for the SD host controller. Accepts a command index and 32-bit argument, builds the 48-bit SD command frame with CRC7, and serializes it MSB-first onto the CMD line. When a response is expected, it then enables the downstream response receiver (`sd_resp_rx`) and waits for completion or timeout before reporting done.

## Interface
Parameters:
- `RESP_TIMEOUT`, default 64: cycles to wait for the receiver's `resp_done` before flagging a timeout (NCR window).

Ports:
- `clk`  in  1  clock. Also the SD clock domain; one CMD bit per cycle.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to send; sampled only in IDLE.
- `cmd_index`  in  6  command index, latched on accepted `start`.
- `argument`  in  32  command argument, latched on accepted `start`.
- `expect_resp`  in  1  response expected, latched on accepted `start`.
- `resp_done`  in  1  receiver's `finished`.
- `sd_cmd_out`  out  1  CMD line data.
- `sd_cmd_oe`  out  1  CMD line output enable; the host drives the line when this is 1.
- `resp_en`  out  1  enable to the response receiver.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  one-cycle pulse, coincident with `done`, when the response timed out.

## Operation
- Frame layout, bit 47 first:
  - bit 47: start bit `0`
  - bit 46: transmission bit `1`
  - bits 45:40: `cmd_index`
  - bits 39:8: `argument`
  - bits 7:1: CRC7
  - bit 0: end bit `1`
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - Computed over bits 47:8, i.e. the first 40 bits transmitted.
  - Computed serially during SEND; no precompute.
- FSM states:
  - IDLE: `oe=0`, `out=1`. On `start`, latch the inputs, clear the CRC and bit counter, and go to SEND.
  - SEND: drive frame bit `47-cnt`, with `cnt` counting 0..47.
    - For `cnt` 0..39, advance the CRC with the outgoing bit.
    - For `cnt` 40..46, shift out CRC[6:0], MSB first.
    - At `cnt=47`, send the end bit. Next state is WAIT_RESP if `expect_resp`, else DONE.
  - WAIT_RESP: `oe=0`, `out=1`, `resp_en=1`, timeout counter increments.
    - `resp_done=1` → DONE, no timeout.
    - Counter reaches `RESP_TIMEOUT-1` with no `resp_done` → DONE with `timeout` set.
    - If both occur in the same cycle, `resp_done` wins.
  - DONE: `done=1` for exactly one cycle, `timeout` as recorded, `resp_en=0`; next state is IDLE.
- `start` outside IDLE is ignored and not queued.
- Input changes after acceptance have no effect.
- Counter widths: bit counter 6 bits; timeout counter `$clog2(RESP_TIMEOUT)+1` bits.

## Timing
- Reset values (asynchronous):
  - state IDLE
  - `sd_cmd_out=1`, `sd_cmd_oe=0`
  - `resp_en=0`, `busy=0`, `done=0`, `timeout=0`
  - all counters and CRC 0
- Reset asserted mid-frame or mid-wait aborts immediately to the reset values; no `done` is produced.
- `start` sampled high at edge N: the start bit appears on `sd_cmd_out` with `oe=1` after edge N+1 (registered outputs). The end bit is after edge N+48.
- `oe` is high for exactly 48 consecutive cycles.
- No response: `done` pulses after edge N+49.
- With response: `resp_en` rises in the cycle after the end bit and falls when DONE is entered.
- The earliest new `start` is accepted in the cycle `done` is high (state IDLE next); back-to-back frames are separated by at least 2 cycles of `oe=0`.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `sd_pkg`:
  - Frame length (48) and CRC7 polynomial (7'h09).
  - Bit-field positions and the FSM state enum.
- Sub-module `sd_crc7`:
  - Serial CRC7 with `clk`, `reset`, `clear`, `en`, `din`, and `crc[6:0]`.
  - Reused later by `sd_resp_rx` for response CRC checking.

## Test plan
- CMD0, arg 0x00000000, `expect_resp=0` → line shows 0x40_00000000_95 over 48 cycles; `done` at N+49; `resp_en` never asserted.
- CMD8, arg 0x000001AA, `expect_resp=1`, `resp_done` driven 10 cycles after the end bit → frame 0x48_000001AA_87; `resp_en` high for 10 cycles; `done=1`, `timeout=0`.
- CMD17, arg 0x00000000, `expect_resp=1`, `resp_done` never driven → frame 0x51_00000000_55; `resp_en` high for 64 cycles, then `done=1` and `timeout=1` together.
- `start` pulsed again at `cnt=20`, and `cmd_index` changed mid-frame → frame unaltered; no second frame sent.
- Reset asserted at `cnt=30` → `oe=0` and `out=1` immediately; no `done`. A subsequent CMD0 transmits correctly (CRC cleared).
- `resp_done` and the timeout terminal count in the same cycle → `done=1`, `timeout=0`.
